// File: rtl/ps2_key_event_fifo.sv
// rtl/ps2_key_event_fifo.sv - folds E0/F0 prefixed PS/2 scancodes into key events and queues them FWFT
module ps2_key_event_fifo #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            i_key_code,
    input  logic                  i_key_strobe,
    output logic [9:0]            o_event_data,
    output logic                  o_event_valid,
    input  logic                  i_event_pop,
    output logic [DEPTH_LOG2:0]   o_event_count,
    output logic                  o_overflow,
    input  logic                  i_overflow_clr
);
    localparam int                  DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] C_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0] C_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
    localparam logic [DEPTH_LOG2-1:0] P_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};

    typedef enum logic {S_IDLE, S_PREFIX} state_t;

    state_t                  r_state;
    logic                    r_brk;
    logic                    r_ext;
    logic                    r_strobe_d;
    logic [9:0]              r_mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   r_wptr;
    logic [DEPTH_LOG2-1:0]   r_rptr;
    logic [DEPTH_LOG2:0]     r_count;
    logic                    r_overflow;

    logic       w_accept;
    logic       w_is_prefix;
    logic       w_is_error;
    logic       w_push;
    logic       w_pop;
    logic       w_full;
    logic       w_wr;
    logic       w_drop;
    logic [9:0] w_push_data;

    assign w_accept    = i_key_strobe & ~r_strobe_d;
    assign w_is_prefix = (i_key_code == 8'hE0) || (i_key_code == 8'hF0);
    assign w_is_error  = (i_key_code == 8'h00) || (i_key_code == 8'hFF);
    assign w_push      = w_accept & ~w_is_prefix & ~w_is_error;
    // Flags only carry meaning while a prefix is pending.
    assign w_push_data = {(r_state == S_PREFIX) & r_brk, (r_state == S_PREFIX) & r_ext, i_key_code};

    assign w_full = (r_count == C_FULL);
    assign w_pop  = i_event_pop & (r_count != '0);
    assign w_wr   = w_push & (~w_full | w_pop);
    assign w_drop = w_push & w_full & ~w_pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_strobe_d <= 1'b0;
            r_state    <= S_IDLE;
            r_brk      <= 1'b0;
            r_ext      <= 1'b0;
        end else begin
            r_strobe_d <= i_key_strobe;
            if (w_accept) begin
                if (i_key_code == 8'hE0) begin
                    r_ext   <= 1'b1;
                    r_state <= S_PREFIX;
                end else if (i_key_code == 8'hF0) begin
                    r_brk   <= 1'b1;
                    r_state <= S_PREFIX;
                end else begin
                    r_brk   <= 1'b0;
                    r_ext   <= 1'b0;
                    r_state <= S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wptr] <= w_push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + P_ONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + P_ONE;
            end
            if (w_wr && !w_pop) begin
                r_count <= r_count + C_ONE;
            end else if (!w_wr && w_pop) begin
                r_count <= r_count - C_ONE;
            end
            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (i_overflow_clr) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign o_event_valid = (r_count != '0);
    assign o_event_data  = o_event_valid ? r_mem[r_rptr] : 10'h000;
    assign o_event_count = r_count;
    assign o_overflow    = r_overflow;
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// tb/tb_ps2_key_event_fifo.sv - directed bench with queue model for ps2_key_event_fifo
module tb_ps2_key_event_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] key_code = 8'h00;
    logic       key_strobe = 1'b0;
    logic [9:0] event_data;
    logic       event_valid;
    logic       event_pop = 1'b0;
    logic [3:0] event_count;
    logic       overflow;
    logic       overflow_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    ps2_key_event_fifo #(.DEPTH_LOG2(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_key_code     (key_code),
        .i_key_strobe   (key_strobe),
        .o_event_data   (event_data),
        .o_event_valid  (event_valid),
        .i_event_pop    (event_pop),
        .o_event_count  (event_count),
        .o_overflow     (overflow),
        .i_overflow_clr (overflow_clr)
    );

    always #5 clk = ~clk;

    // Reference model: a queue of events plus prefix flags.
    logic [9:0] mq[$];
    bit m_prev = 0;
    bit m_brk = 0;
    bit m_ext = 0;
    bit m_ovf = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
            m_prev = 0; m_brk = 0; m_ext = 0; m_ovf = 0;
        end else begin
            bit acc, popping, was_full, push, drop;
            logic [9:0] ev;
            acc = key_strobe && !m_prev;
            m_prev = key_strobe;
            push = 0;
            drop = 0;
            ev = '0;
            if (acc) begin
                if (key_code == 8'hE0) m_ext = 1;
                else if (key_code == 8'hF0) m_brk = 1;
                else begin
                    if (key_code != 8'h00 && key_code != 8'hFF) begin
                        push = 1;
                        ev = {m_brk, m_ext, key_code};
                    end
                    m_brk = 0;
                    m_ext = 0;
                end
            end
            was_full = (mq.size() == 8);
            popping = event_pop && (mq.size() > 0);
            if (popping) void'(mq.pop_front());
            if (push) begin
                if (!was_full || popping) mq.push_back(ev);
                else drop = 1;
            end
            if (drop) m_ovf = 1;
            else if (overflow_clr) m_ovf = 0;
        end
    end

    always @(negedge clk) begin
        logic [9:0] exp_data;
        exp_data = (mq.size() > 0) ? mq[0] : 10'h000;
        checks++;
        if (event_valid !== (mq.size() > 0) || event_data !== exp_data ||
            event_count !== 4'(mq.size()) || overflow !== m_ovf) begin
            errors++;
            $display("FAIL model t=%0t got valid=%0b data=%03h count=%0d ovf=%0b want valid=%0b data=%03h count=%0d ovf=%0b",
                     $time, event_valid, event_data, event_count, overflow,
                     mq.size() > 0, exp_data, mq.size(), m_ovf);
        end
    end

    task automatic expect_eq(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, got, want);
        end
    endtask

    task automatic send(input logic [7:0] b, input int hold);
        @(negedge clk);
        key_code = b;
        key_strobe = 1'b1;
        repeat (hold) @(negedge clk);
        key_strobe = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop1();
        @(negedge clk);
        event_pop = 1'b1;
        @(negedge clk);
        event_pop = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);
        expect_eq("rst_valid", 16'(event_valid), 16'h0);
        expect_eq("rst_data", 16'(event_data), 16'h000);
        expect_eq("rst_count", 16'(event_count), 16'h0);
        expect_eq("rst_ovf", 16'(overflow), 16'h0);
        #2 rst = 1'b0;

        // Single held strobe gives one event, visible one cycle after the edge.
        @(negedge clk);
        key_code = 8'h1C;
        key_strobe = 1'b1;
        @(negedge clk);
        expect_eq("latency_valid", 16'(event_valid), 16'h1);
        expect_eq("latency_data", 16'(event_data), 16'h01C);
        repeat (2) @(negedge clk);
        key_strobe = 1'b0;
        @(negedge clk);
        expect_eq("held_count", 16'(event_count), 16'h1);
        pop1();
        expect_eq("pop_valid", 16'(event_valid), 16'h0);
        expect_eq("pop_count", 16'(event_count), 16'h0);

        send(8'hF0, 1);
        expect_eq("prefix_no_push", 16'(event_count), 16'h0);
        send(8'h1C, 1);
        expect_eq("brk_data", 16'(event_data), 16'h21C);
        pop1();
        send(8'hE0, 1); send(8'hF0, 1); send(8'h75, 1);
        expect_eq("e0f0_data", 16'(event_data), 16'h375);
        expect_eq("e0f0_count", 16'(event_count), 16'h1);
        pop1();
        send(8'hF0, 1); send(8'hE0, 1); send(8'h6B, 1);
        expect_eq("f0e0_data", 16'(event_data), 16'h36B);
        pop1();
        send(8'hE0, 1); send(8'h00, 1); send(8'h1C, 1);
        expect_eq("err_clear_data", 16'(event_data), 16'h01C);
        expect_eq("err_clear_count", 16'(event_count), 16'h1);
        pop1();

        // Overflow: nine pushes into eight slots.
        for (int i = 0; i < 9; i++) send(8'h15 + 8'(i), 1);
        expect_eq("full_count", 16'(event_count), 16'h8);
        expect_eq("ovf_set", 16'(overflow), 16'h1);
        for (int i = 0; i < 8; i++) begin
            expect_eq("ovf_order", 16'(event_data), 16'h015 + 16'(i));
            pop1();
        end
        expect_eq("drained", 16'(event_count), 16'h0);
        expect_eq("ovf_sticky", 16'(overflow), 16'h1);
        @(negedge clk);
        overflow_clr = 1'b1;
        @(negedge clk);
        overflow_clr = 1'b0;
        expect_eq("ovf_clr", 16'(overflow), 16'h0);

        // Full FIFO with simultaneous push and pop.
        for (int i = 0; i < 8; i++) send(8'h20 + 8'(i), 1);
        @(negedge clk);
        key_code = 8'h30;
        key_strobe = 1'b1;
        event_pop = 1'b1;
        @(negedge clk);
        key_strobe = 1'b0;
        event_pop = 1'b0;
        expect_eq("fullpp_count", 16'(event_count), 16'h8);
        expect_eq("fullpp_ovf", 16'(overflow), 16'h0);
        expect_eq("fullpp_head", 16'(event_data), 16'h021);
        repeat (7) pop1();
        expect_eq("fullpp_last", 16'(event_data), 16'h030);
        pop1();
        pop1();
        expect_eq("pop_empty_count", 16'(event_count), 16'h0);
        expect_eq("pop_empty_valid", 16'(event_valid), 16'h0);

        // Asynchronous reset after a break prefix discards it and the queue.
        send(8'h22, 1);
        send(8'hF0, 1);
        #3 rst = 1'b1;
        #2 rst = 1'b0;
        send(8'h1C, 1);
        expect_eq("rst_mid_data", 16'(event_data), 16'h01C);
        expect_eq("rst_mid_count", 16'(event_count), 16'h1);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
